seven_seg_scan_counter: RTL and testbench

- Parametrised N-digit BCD up/down counter with a time-multiplexed seven-segment driver.
- Successor to the single-digit 0-9 sequencer.
- Adds:
  - configurable digit count and tick/scan rates
  - synchronous reset, count enable, direction control and parallel load
  - rollover pulse
  - one shared segment bus plus one-hot digit select, for multi-digit boards.

---
 rtl/seven_seg_scan_counter.sv | 199 +++++++++++++++++++
 tb/tb_seven_seg_scan_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_counter.sv
// seven_seg_scan_counter
//   N-digit BCD up/down counter driving a time-multiplexed seven-segment
//   display through one shared segment bus and a one-hot digit select.
//
// Parameters
//   DIGITS   number of BCD digits (1..8)
//   TICK_DIV clk cycles per count step (>= 2)
//   SCAN_DIV clk cycles each digit is held on the bus (>= 1)
//
// Ports
//   clk      system clock
//   rst      synchronous reset, active-high, highest priority
//   en       count enable; tick prescaler and count hold while low
//   up       direction, 1 = increment, 0 = decrement
//   load     parallel load strobe, wins over a step in the same cycle
//   load_val BCD load value, digit 0 in [3:0]; nibbles > 9 load as 0
//   count    current BCD count, digit 0 in [3:0]
//   wrap     one-cycle pulse after a 9..9->0..0 or 0..0->9..9 step
//   seg      segments {a,b,c,d,e,f,g}, active-high
//   an       one-hot digit select, active-high, bit i = digit i
//
// Optional feature
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN: when defined, a selected digit i >= 1
//   that is 0 with all higher digits also 0 shows a blank segment pattern.
//   Digit 0 is never blanked.
//
// Handshake: none. Inputs are sampled every rising clk edge; load and step
// are single-cycle events, wrap is a single-cycle registered pulse.

module seven_seg_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV) + 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = 4 * DIGITS;

    logic [TW-1:0]     tick_q;
    logic [SW-1:0]     scan_q;
    logic [IW-1:0]     idx_q;
    logic [CW-1:0]     count_q;
    logic              wrap_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;

    logic              step;
    logic              tick_term;
    logic              scan_term;
    logic [CW-1:0]     count_step;
    logic [CW-1:0]     load_clean;
    logic              carry;
    logic [3:0]        dig;
    logic [3:0]        cur_digit;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] an_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign tick_term = (tick_q == TW'(TICK_DIV - 1));
    assign scan_term = (scan_q == SW'(SCAN_DIV - 1));
    assign step      = en && tick_term;

    // Ripple BCD increment/decrement. The carry (or borrow) that survives
    // past the top digit is exactly the rollover condition, so it doubles
    // as the wrap request.
    always_comb begin
        count_step = count_q;
        carry      = 1'b1;
        dig        = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (dig == 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = dig + 4'd1;
                        carry                = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = dig - 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
        end
    end

    // Load value with every non-BCD nibble forced to 0.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Display path: select the digit under the scan index and decode it.
    // Uses the count register of the current cycle, so a count change shows
    // up on seg one cycle later.
    always_comb begin
        cur_digit = 4'd0;
        an_next   = '0;
        for (int j = 0; j < DIGITS; j++) begin
            if (int'(idx_q) == j) begin
                cur_digit  = count_q[4*j +: 4];
                an_next[j] = 1'b1;
            end
        end
        seg_next = decode(cur_digit);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        begin
            logic blank;
            blank = (idx_q != '0);
            for (int j = 0; j < DIGITS; j++) begin
                if (j >= int'(idx_q) && count_q[4*j +: 4] != 4'd0) begin
                    blank = 1'b0;
                end
            end
            if (blank) begin
                seg_next = 7'b0000000;
            end
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q  <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            an_q    <= DIGITS'(1);
            seg_q   <= 7'b1111110;
        end else begin
            // Count path: load beats step and restarts the prescaler.
            if (load) begin
                tick_q  <= '0;
                count_q <= load_clean;
            end else if (en) begin
                tick_q <= tick_term ? '0 : tick_q + TW'(1);
                if (tick_term) begin
                    count_q <= count_step;
                end
            end
            wrap_q <= step && !load && carry;

            // Scan path runs regardless of en and load.
            if (scan_term) begin
                scan_q <= '0;
                idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                scan_q <= scan_q + SW'(1);
            end
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_seven_seg_scan_counter.sv
// Directed bench for seven_seg_scan_counter with DIGITS=2, TICK_DIV=4,
// SCAN_DIV=2. A vector table drives the counting behaviour cycle by cycle;
// hand-written sequences cover reset state and the scan/display path.

module tb_seven_seg_scan_counter;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    // Clock / reset block
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] an;

    always #5 clk = ~clk;

    seven_seg_scan_counter #(
        .DIGITS  (DIGITS),
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .wrap    (wrap),
        .seg     (seg),
        .an      (an)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [7:0] lv;
        int         reps;
        logic [7:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Driver tasks
    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [7:0] v);
        @(negedge clk);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] v, input int reps,
                       input logic [7:0] ec, input logic ew);
        vec_t x;
        x.rst = r; x.en = e; x.up = u; x.load = l; x.lv = v;
        x.reps = reps; x.exp_count = ec; x.exp_wrap = ew;
        vecs.push_back(x);
    endtask

    // Scan check: reset, load a value with en low, then follow an/seg.
    // After reset the index sits at 0 with a fresh prescaler, so an reads
    // 01,01,10,10,... starting with the first edge after reset.
    task automatic scan_test(input logic [7:0] val, input logic [6:0] seg_lo,
                             input logic [6:0] seg_hi);
        logic [1:0] an_exp;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, val);
        tick();
        check("scan_an_k1", {14'd0, an}, 16'h0001);
        check("scan_seg_k1", {9'd0, seg}, {9'd0, 7'b1111110});
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 2; k <= 9; k++) begin
            tick();
            an_exp = ((((k - 1) / 2) % 2) == 0) ? 2'b01 : 2'b10;
            check("scan_an", {14'd0, an}, {14'd0, an_exp});
            check("scan_seg", {9'd0, seg},
                  {9'd0, (an_exp == 2'b01) ? seg_lo : seg_hi});
            check("scan_count", {8'd0, count}, {8'd0, val});
        end
    endtask

    initial begin
        logic [8:0] e;

        // Vector table: counting, rollover, load priority, hold, mid reset
        add(0,1,1,0,8'h00, 3,8'h00,0);
        add(0,1,1,0,8'h00, 1,8'h01,0);
        add(0,1,1,0,8'h00, 3,8'h01,0);
        add(0,1,1,0,8'h00, 1,8'h02,0);
        add(0,1,1,1,8'h99, 1,8'h99,0);
        add(0,1,1,0,8'h00, 3,8'h99,0);
        add(0,1,1,0,8'h00, 1,8'h00,1);
        add(0,1,1,0,8'h00, 1,8'h00,0);
        add(0,1,1,1,8'h19, 1,8'h19,0);
        add(0,1,1,0,8'h00, 3,8'h19,0);
        add(0,1,1,0,8'h00, 1,8'h20,0);
        add(0,1,0,1,8'h00, 1,8'h00,0);
        add(0,1,0,0,8'h00, 3,8'h00,0);
        add(0,1,0,0,8'h00, 1,8'h99,1);
        add(0,1,0,0,8'h00, 1,8'h99,0);
        add(0,1,0,1,8'h10, 1,8'h10,0);
        add(0,1,0,0,8'h00, 3,8'h10,0);
        add(0,1,0,0,8'h00, 1,8'h09,0);
        add(0,1,1,1,8'h3F, 1,8'h30,0);
        add(0,0,1,0,8'h00,20,8'h30,0);
        add(0,1,1,0,8'h00, 3,8'h30,0);
        add(0,1,1,1,8'h55, 1,8'h55,0);
        add(0,1,1,0,8'h00, 3,8'h55,0);
        add(0,1,1,0,8'h00, 1,8'h56,0);
        add(0,1,1,0,8'h00, 2,8'h56,0);
        add(1,1,1,0,8'h00, 1,8'h00,0);
        add(0,1,1,0,8'h00, 3,8'h00,0);
        add(0,1,1,0,8'h00, 1,8'h01,0);
        add(0,1,1,1,8'h99, 1,8'h99,0);
        add(0,1,1,0,8'h00, 3,8'h99,0);
        add(0,1,1,1,8'h42, 1,8'h42,0);
        add(0,1,1,0,8'h00, 2,8'h42,0);
        add(0,0,1,0,8'h00, 5,8'h42,0);
        add(0,1,1,0,8'h00, 1,8'h42,0);
        add(0,1,1,0,8'h00, 1,8'h43,0);

        // Reset state held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        check("rst_count", {8'd0, count}, 16'h0000);
        check("rst_wrap", {15'd0, wrap}, 16'h0000);
        check("rst_an", {14'd0, an}, 16'h0001);
        check("rst_seg", {9'd0, seg}, {9'd0, 7'b1111110});

        // Apply the table through the expected-value scoreboard
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv);
                exp_q.push_back({vecs[i].exp_wrap, vecs[i].exp_count});
                tick();
                e = exp_q.pop_front();
                check($sformatf("vec%0d_count", i), {8'd0, count}, {8'd0, e[7:0]});
                check($sformatf("vec%0d_wrap", i), {15'd0, wrap}, {15'd0, e[8]});
            end
        end

        // Scan path: 47 shows 7 then 4
        scan_test(8'h47, 7'b1110000, 7'b0110011);
        // Leading zero on the upper digit
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        scan_test(8'h07, 7'b1110000, 7'b0000000);
`else
        scan_test(8'h07, 7'b1110000, 7'b1111110);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
